// File: rtl/axi_sram_slave.sv
// AXI slave responder over a word-addressed SRAM model; independent read and write FSMs,
// one outstanding transaction per direction. Define AXI_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states.
module axi_sram_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  dbg_rstate_o,
  output logic [1:0]  dbg_wstate_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // valid, once raised, holds its payload stable until that edge.
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} wstate_t;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  rstate_t     rstate_q;
  logic [3:0]  rid_q;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rbeat_q;
  logic [1:0]  rsize_q;
  logic        rfixed_q;
  logic [31:0] rdata_q;
  logic        rvalid_q, rlast_q;

  wstate_t     wstate_q;
  logic [3:0]  wid_q;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wbeat_q;
  logic [1:0]  wsize_q;
  logic        wfixed_q;
  logic        werr_q, werr_d;
  logic        wready_q, bvalid_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
  logic        wr_en;

`ifdef AXI_SLAVE_WAIT_EN
  logic [3:0]  rwait_q, wwait_q;
`endif

  function automatic logic [1:0] eff_size(input logic [2:0] s);
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // FIXED keeps the address; every other burst encoding advances like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] sz,
                                            input logic fixed);
    return fixed ? a : a + (32'd1 << sz);
  endfunction

  assign raddr_d = next_addr(raddr_q, rsize_q, rfixed_q);
  assign waddr_d = next_addr(waddr_q, wsize_q, wfixed_q);
  assign werr_d  = werr_q | (wlast != (wbeat_q == wlen_q));
  assign wr_en   = wready_q & wvalid;

  assign arready      = (rstate_q == R_IDLE);
  assign awready      = (wstate_q == W_IDLE);
  assign rid          = rid_q;
  assign rdata        = rdata_q;
  assign rresp        = 2'b00;
  assign rlast        = rlast_q;
  assign rvalid       = rvalid_q;
  assign wready       = wready_q;
  assign bid          = bid_q;
  assign bresp        = bresp_q;
  assign bvalid       = bvalid_q;
  assign dbg_rstate_o = rstate_q;
  assign dbg_wstate_o = wstate_q;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Memory is deliberately not reset; a same-edge write is seen only by later loads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[waddr_q[ADDR_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rfixed_q <= 1'b0;
      rbeat_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
      rwait_q  <= '0;
`endif
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (arvalid) begin
            rid_q    <= arid;
            raddr_q  <= araddr;
            rlen_q   <= arlen;
            rsize_q  <= eff_size(arsize);
            rfixed_q <= (arburst == 2'b00);
            rbeat_q  <= '0;
`ifdef AXI_SLAVE_WAIT_EN
            rwait_q  <= 4'(WAIT_CYCLES - 1);
            rstate_q <= R_WAIT;
`else
            rdata_q  <= mem_q[araddr[ADDR_W+1:2]];
            rlast_q  <= (arlen == 8'd0);
            rvalid_q <= 1'b1;
            rstate_q <= R_DATA;
`endif
          end
        end
        R_WAIT: begin
`ifdef AXI_SLAVE_WAIT_EN
          // First word is fetched when the wait expires so it reflects writes made meanwhile.
          if (rwait_q == 4'd0) begin
            rdata_q  <= mem_q[raddr_q[ADDR_W+1:2]];
            rlast_q  <= (rlen_q == 8'd0);
            rvalid_q <= 1'b1;
            rstate_q <= R_DATA;
          end else begin
            rwait_q  <= rwait_q - 4'd1;
          end
`else
          rstate_q <= R_IDLE;
`endif
        end
        R_DATA: begin
          if (rready) begin
            if (rbeat_q == rlen_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              rstate_q <= R_IDLE;
            end else begin
              raddr_q  <= raddr_d;
              rdata_q  <= mem_q[raddr_d[ADDR_W+1:2]];
              rbeat_q  <= rbeat_q + 8'd1;
              rlast_q  <= ((rbeat_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wfixed_q <= 1'b0;
      wbeat_q  <= '0;
      werr_q   <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
`ifdef AXI_SLAVE_WAIT_EN
      wwait_q  <= '0;
`endif
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (awvalid) begin
            wid_q    <= awid;
            waddr_q  <= awaddr;
            wlen_q   <= awlen;
            wsize_q  <= eff_size(awsize);
            wfixed_q <= (awburst == 2'b00);
            wbeat_q  <= '0;
            werr_q   <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
            wwait_q  <= 4'(WAIT_CYCLES - 1);
            wstate_q <= W_WAIT;
`else
            wready_q <= 1'b1;
            wstate_q <= W_DATA;
`endif
          end
        end
        W_WAIT: begin
`ifdef AXI_SLAVE_WAIT_EN
          if (wwait_q == 4'd0) begin
            wready_q <= 1'b1;
            wstate_q <= W_DATA;
          end else begin
            wwait_q  <= wwait_q - 4'd1;
          end
`else
          wstate_q <= W_IDLE;
`endif
        end
        W_DATA: begin
          // The burst ends on the beat count; a disagreeing wlast only flags SLVERR.
          if (wvalid) begin
            werr_q <= werr_d;
            if (wbeat_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
              bresp_q  <= werr_d ? 2'b10 : 2'b00;
              wstate_q <= W_RESP;
            end else begin
              waddr_q  <= waddr_d;
              wbeat_q  <= wbeat_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus randomized bursts checked against a word-array model.
module tb_axi_sram_slave;

  localparam int ADDR_W      = 12;
  localparam int WAIT_CYCLES = 2;
`ifdef AXI_SLAVE_WAIT_EN
  localparam int RD_LAT = 1 + WAIT_CYCLES;
`else
  localparam int RD_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, rready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arready, awready, rlast, rvalid, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp, dbg_rstate, dbg_wstate;

  axi_sram_slave #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_rstate_o(dbg_rstate), .dbg_wstate_o(dbg_wstate)
  );

  // Clock / reset: posedge at 5, 15, ...; inputs driven and outputs sampled on negedges.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain word array, unwritten words stay X on both sides.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic        wl_q [$];
  logic [31:0] exp_q [$];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << ADDR_W));
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    int bytes;
    bytes = (size > 3'd2) ? 4 : (1 << size);
    return (burst == 2'b00) ? a : a + 32'(bytes);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wd_q.push_back(d);
    ws_q.push_back(s);
    wl_q.push_back(l);
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output logic err);
    logic [31:0] a;
    a = addr;
    err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      for (int b = 0; b < 4; b++)
        if (ws_q[k][b]) ref_mem[widx(a)][8*b +: 8] = wd_q[k][8*b +: 8];
      if (wl_q[k] != (k == int'(len))) err = 1'b1;
      a = step_addr(a, size, burst);
    end
  endtask

  // Write driver: AW, then the queued W beats, then B with an optional bready stall.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int b_stall);
    logic exp_err;
    int n;
    model_write(addr, len, size, burst, exp_err);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wvalid = 1'b1; wdata = wd_q[k]; wstrb = ws_q[k]; wlast = wl_q[k];
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("w_ready", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, exp_err ? 2'b10 : 2'b00);
    for (int s = 0; s < b_stall; s++) begin
      @(negedge clk);
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_id", bid, id);
      chk("b_hold_resp", bresp, exp_err ? 2'b10 : 2'b00);
      chk("aw_blocked", awready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", bvalid, 0);
    chk("aw_back", awready, 1);
    wd_q.delete(); ws_q.delete(); wl_q.delete();
  endtask

  // Read driver: mode 0 rready always high, 1 alternating starting low, 2 random.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [31:0] a;
    int n, lat, cyc;
    logic rr;
    a = addr;
    exp_q.delete();
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(ref_mem[widx(a)]);
      a = step_addr(a, size, burst);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, RD_LAT);
    cyc = 0;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      rr = 1'b0;
      while (!rr && n < 50) begin
        chk("r_valid", rvalid, 1);
        chk("r_data", rdata, exp_q[k]);
        chk("r_last", rlast, (k == int'(len)));
        chk("r_id", rid, id);
        chk("r_resp", rresp, 2'b00);
        rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
        if (n == 49) rr = 1'b1;
        rready = rr;
        cyc++; n++;
        @(negedge clk);
      end
    end
    rready = 1'b0;
    chk("r_done", rvalid, 0);
    chk("ar_back", arready, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int n;

    // Reset state.
    @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);

    // W presented before AW must stall.
    wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_stall_pre_aw", wready, 0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    // Single write then single read.
    push_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    axi_write(4'hA, 32'h100, 8'd0, 3'd2, 2'b01, 0);
    axi_read(4'h3, 32'h100, 8'd0, 3'd2, 2'b01, 0);

    // Four-beat INCR read with rready toggling.
    for (int i = 0; i < 4; i++) push_beat(32'(i + 1), 4'hF, (i == 3));
    axi_write(4'h1, 32'h200, 8'd3, 3'd2, 2'b01, 0);
    axi_read(4'h5, 32'h200, 8'd3, 3'd2, 2'b01, 1);

    // Byte-lane writes onto a zeroed word.
    push_beat(32'h0, 4'hF, 1'b1);
    axi_write(4'h2, 32'h300, 8'd0, 3'd2, 2'b01, 0);
    push_beat(32'h0000_00AA, 4'b0001, 1'b1);
    axi_write(4'h2, 32'h300, 8'd0, 3'd0, 2'b01, 0);
    push_beat(32'h00BB_0000, 4'b0100, 1'b1);
    axi_write(4'h2, 32'h300, 8'd0, 3'd0, 2'b01, 0);
    axi_read(4'h2, 32'h300, 8'd0, 3'd2, 2'b01, 0);

    // FIXED read repeats one word; early wlast gives SLVERR but both beats land.
    push_beat(32'h1234_5678, 4'hF, 1'b1);
    axi_write(4'h4, 32'h104, 8'd0, 3'd2, 2'b01, 0);
    axi_read(4'h6, 32'h104, 8'd2, 3'd2, 2'b00, 0);
    push_beat(32'hCAFE_0001, 4'hF, 1'b1);
    push_beat(32'hCAFE_0002, 4'hF, 1'b0);
    axi_write(4'h7, 32'h400, 8'd1, 3'd2, 2'b01, 0);
    axi_read(4'h7, 32'h400, 8'd1, 3'd2, 2'b01, 0);

    // B stalled for five cycles.
    push_beat(32'h5555_AAAA, 4'hF, 1'b1);
    axi_write(4'h9, 32'h108, 8'd0, 3'd2, 2'b01, 5);

    // Index wrap at the top of memory and address aliasing.
    push_beat(32'hA0A0_A0A0, 4'hF, 1'b0);
    push_beat(32'hB0B0_B0B0, 4'hF, 1'b1);
    axi_write(4'h3, 32'h3FFC, 8'd1, 3'd2, 2'b10, 0);
    axi_read(4'h3, 32'h0, 8'd0, 3'd2, 2'b01, 0);
    axi_read(4'h8, 32'h4100, 8'd0, 3'd2, 2'b01, 0);

    // Randomized bursts over a pre-filled region.
    for (int i = 0; i < 64; i++) push_beat($urandom, 4'hF, (i == 63));
    axi_write(4'h0, 32'h800, 8'd63, 3'd2, 2'b01, 0);
    for (int t = 0; t < 12; t++) begin
      a = 32'h800 + 32'($urandom_range(0, 32'hC0));
      len = 8'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 3));
      for (int k = 0; k <= int'(len); k++)
        push_beat($urandom, 4'($urandom_range(0, 15)),
                  ((t % 4) == 3) ? (k == 0) : (k == int'(len)));
      axi_write(4'($urandom_range(0, 15)), a, len, sz, bu, $urandom_range(0, 2));
      a = 32'h800 + 32'($urandom_range(0, 32'hC0));
      axi_read(4'($urandom_range(0, 15)), a, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2);
    end

    // Reset in the middle of a read burst.
    for (int i = 0; i < 4; i++) push_beat(32'h5000_0000 + 32'(i), 4'hF, (i == 3));
    axi_write(4'h1, 32'h500, 8'd3, 3'd2, 2'b01, 0);
    @(negedge clk);
    arid = 4'hC; araddr = 32'h500; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rready = 1'b0;
    chk("mid_rd_beat2", rdata, 32'h5000_0002);
    #2 reset = 1'b1;
    #1;
    chk("mid_rd_rvalid_async", rvalid, 0);
    chk("mid_rd_rlast_async", rlast, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_arready", arready, 1);
    chk("post_rst_rdata", rdata, 0);
    @(negedge clk);
    chk("post_rst_quiet", rvalid, 0);
    axi_read(4'hD, 32'h508, 8'd0, 3'd2, 2'b01, 0);

    // Reset in the middle of a write burst keeps the beats already written.
    @(negedge clk);
    awid = 4'hE; awaddr = 32'h600; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = 32'h6000_0000 + 32'(k); wstrb = 4'hF; wlast = 1'b0;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("mid_wr_wready", wready, 1);
      ref_mem[widx(32'h600 + 32'(4 * k))] = 32'h6000_0000 + 32'(k);
      @(negedge clk);
    end
    wvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_wr_wready_async", wready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_wr_no_b", bvalid, 0);
    chk("mid_wr_awready", awready, 1);
    axi_read(4'h1, 32'h600, 8'd1, 3'd2, 2'b01, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout simulation did not finish checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
